// File: rtl/aux_count_ctrl.sv
// aux_count_ctrl
//   Sequencing controller for the auxiliary counter register. A start request
//   clears the register, then increments it once every TICK_DIV cycles until
//   it equals the limit sampled at start, then pulses done for one cycle.
//   This block is the only driver of the register's clear/enable/data inputs.
//
// Parameters
//   WIDTH    : width of counter value, limit and register interface
//   TICK_DIV : clock cycles per increment while running (>= 1)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active high
//   start_i   in   start request, accepted only when idle
//   stop_i    in   abort request (clear/run), blocks start when idle
//   limit_i   in   terminal count, sampled when start is accepted
//   aux_q_i   in   current register value
//   aux_d_o   out  next register value, aux_q_i + 1 (wraps)
//   aux_en_o  out  register load enable
//   aux_clr_o out  register clear
//   busy_o    out  sequence in progress
//   done_o    out  one-cycle completion pulse
//
// Optional build macro
//   AUX_COUNT_CTRL_AUTORELOAD_EN : DONE restarts the sequence with the
//   retained limit instead of returning to idle; busy stays high in DONE.

module aux_count_ctrl #(
  parameter int WIDTH    = 6,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic [WIDTH-1:0] aux_q_i,
  output logic [WIDTH-1:0] aux_d_o,
  output logic             aux_en_o,
  output logic             aux_clr_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] limit_q, limit_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic             match;
  logic             tick;

  assign aux_d_o = aux_q_i + WIDTH'(1);
  assign match   = (aux_q_i == limit_q);
  assign tick    = (presc == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      limit_q <= '0;
      presc   <= '0;
    end else begin
      state   <= state_nxt;
      limit_q <= limit_nxt;
      presc   <= presc_nxt;
    end
  end

  // Prescaler defaults to 0 so it is held at 0 in every state except RUN.
  always_comb begin
    state_nxt = state;
    limit_nxt = limit_q;
    presc_nxt = '0;
    aux_en_o  = 1'b0;
    aux_clr_o = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_nxt = CLEAR;
          limit_nxt = limit_i;
        end
      end
      CLEAR: begin
        aux_clr_o = 1'b1;
        busy_o    = 1'b1;
        state_nxt = stop_i ? IDLE : RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        // Abort beats completion, completion beats counting; the limit
        // match is evaluated every cycle, independent of the tick.
        if (stop_i) begin
          state_nxt = IDLE;
        end else if (match) begin
          state_nxt = DONE;
        end else if (tick) begin
          aux_en_o = 1'b1;
        end else begin
          presc_nxt = presc + PW'(1);
        end
      end
      DONE: begin
        done_o = 1'b1;
`ifdef AUX_COUNT_CTRL_AUTORELOAD_EN
        busy_o    = 1'b1;
        state_nxt = stop_i ? IDLE : CLEAR;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
